irig_parse: RTL and testbench
=============================

# irig_parse

IRIG-B (DC level-shift, 100 pps) time-code decoder. Samples the external B-code line, classifies each pulse as 0, 1 or P (position marker) by its high width, and aligns to the frame. It then extracts BCD seconds, minutes, hours, day-of-year and year. It sits behind the board's timing input and feeds the local time/PPS logic.

## Interface
- bcode_0_flag, 24'd99_999: nominal high width of a "0" symbol in clk cycles (2 ms at 50 MHz).
- bcode_1_flag, 24'd249_999: nominal high width of a "1" symbol (5 ms).
- bcode_p_flag, 24'd399_999: nominal high width of a P symbol (8 ms).
- clk  in  1  system clock (50 MHz nominal).
- rst_n  in  1  reset, asynchronous, active-low.
- ex_bcode_signal  in  1  raw IRIG-B input, asynchronous to clk.
- second_units  out  4  BCD seconds units.
- second_tens  out  3  BCD seconds tens.
- minute_units  out  4  BCD minutes units.
- minute_tens  out  3  BCD minutes tens.
- hour_units  out  4  BCD hours units.
- hour_tens  out  2  BCD hours tens.
- day_units  out  4  BCD day-of-year units.
- day_tens  out  4  BCD day-of-year tens.
- day_hunds  out  2  BCD day-of-year hundreds.
- year_units  out  4  BCD year units.
- year_tens  out  4  BCD year tens.
- time_flag  out  1  one-clk pulse when a new decoded time is loaded onto the outputs.

## Operation
- Input passes through a 2-flop synchronizer; rising and falling edges are detected on the synchronized signal.
- A 24-bit saturating counter clears on a rising edge and counts while the input is high. On a falling edge, width W is classified:
  - W < bcode_0_flag/2: glitch. Ignored and produces no symbol.
  - W < (bcode_0_flag+bcode_1_flag)/2: symbol 0.
  - W < (bcode_1_flag+bcode_p_flag)/2: symbol 1.
  - W ≤ bcode_p_flag + (bcode_p_flag−bcode_1_flag)/2: symbol P.
  - Anything longer: error. Drops sync.
- Frame sync FSM has states HUNT and LOCKED, with a 7-bit index 0..99.
  - Two consecutive P symbols in any state: index ← 0 (this P is Pr), state ← LOCKED, field register cleared.
  - In LOCKED, every other symbol increments the index.
  - A P is required at indices 9, 19, …, 99.
  - A non-P at a marker index, a P at a non-marker index (except the Pr pair rule), an error, or index > 99: state ← HUNT.
- Data bits are stored by index (value 1 or 0), LSB first within each field:
  - seconds units 1-4, tens 6-8
  - minutes units 10-13, tens 15-17
  - hours units 20-23, tens 25-26
  - day units 30-33, tens 35-38, hundreds 40-41
  - year units 50-53, tens 55-58
- Indices 5, 14, 24, 34, 42-48, 54 and 60-98 are don't-care.
- When P6 (index 59) is accepted in LOCKED, all eleven fields are copied to the outputs together and time_flag pulses. Outputs hold until the next complete frame.
- No BCD range checking. Values are passed through as received.

## Timing
- Reset: all BCD outputs 0, time_flag 0, FSM HUNT, index 0, counters 0.
- Symbol decision occurs 3 clk after the falling edge of ex_bcode_signal: 2 cycles of synchronizer plus 1 registered classify.
- time_flag is asserted the clk after the index-59 symbol is classified, exactly 1 clk wide. Outputs change on that same clk.
- Reset mid-frame: everything returns to reset values immediately, and a full Pr pair is needed before the next update.

## Structure
- Shared package holds: symbol enum (SYM_0, SYM_1, SYM_P, SYM_ERR), FSM state enum, marker/field index constants.
- One natural sub-module, irig_symbol_classifier: synchronizer, width counter, thresholds. Outputs sym_valid and sym.
- Top level holds the frame FSM, the field register and the output latch.

## Test plan
- Widths at 50 MHz, 10 ms bit period: P high 399_998 clk, 1 high 249_998, 0 high 99_998.
- Frame P,P followed by fields 08 s, 48 min, 01 h, day 251, year 21 -> after index 59 decodes:
  - second_units 8, second_tens 0
  - minute_units 8, minute_tens 4
  - hour_units 1, hour_tens 0
  - day 1/5/2
  - year 1/2
  - one time_flag pulse
- The same frame repeated continuously -> exactly one time_flag per 100 symbols (every 50_000_000 clk), values stable.
- Frame with index 29 sent as 0 instead of P -> no time_flag, outputs unchanged, relock on next P,P.
- 1_000-clk glitches inserted in low periods -> ignored, decode unchanged.
- Reset asserted at index 40, released -> outputs 0 and no flag until a full Pr-aligned frame completes.

Source files
------------

// File: rtl/irig_parse_pkg.sv
// Shared types and frame-layout constants for the IRIG-B decoder.
package irig_parse_pkg;

  typedef enum logic [1:0] {SYM_0, SYM_1, SYM_P, SYM_ERR} sym_t;
  typedef enum logic {HUNT, LOCKED} state_t;

  localparam int LAST_IDX = 99;
  localparam int P6_IDX   = 59;

  // LSB index of each BCD field within the 100-symbol frame
  localparam int SEC_U_LSB  = 1;
  localparam int SEC_T_LSB  = 6;
  localparam int MIN_U_LSB  = 10;
  localparam int MIN_T_LSB  = 15;
  localparam int HOUR_U_LSB = 20;
  localparam int HOUR_T_LSB = 25;
  localparam int DAY_U_LSB  = 30;
  localparam int DAY_T_LSB  = 35;
  localparam int DAY_H_LSB  = 40;
  localparam int YEAR_U_LSB = 50;
  localparam int YEAR_T_LSB = 55;

  typedef struct packed {
    logic [3:0] year_t;
    logic [3:0] year_u;
    logic [1:0] day_h;
    logic [3:0] day_t;
    logic [3:0] day_u;
    logic [1:0] hour_t;
    logic [3:0] hour_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
  } irig_time_t;

  function automatic logic is_marker(input logic [6:0] idx);
    return (idx % 7'd10) == 7'd9;
  endfunction

  function automatic logic in_field(input logic [6:0] idx, input int lsb, input int w);
    return (int'(idx) >= lsb) && (int'(idx) < lsb + w);
  endfunction

endpackage

// File: rtl/irig_symbol_classifier.sv
// Synchronizes the B-code line and classifies each high pulse as 0/1/P/error.
// sym_valid pulses 3 clk after the input's falling edge; glitches yield no symbol.
module irig_symbol_classifier
  import irig_parse_pkg::*;
#(
  parameter logic [23:0] bcode_0_flag = 24'd99_999,
  parameter logic [23:0] bcode_1_flag = 24'd249_999,
  parameter logic [23:0] bcode_p_flag = 24'd399_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ex_bcode_signal,
  output logic sym_valid,
  output sym_t sym
);

  // 25-bit thresholds so the sums cannot overflow
  localparam logic [24:0] T_GLITCH = {1'b0, bcode_0_flag} >> 1;
  localparam logic [24:0] T_01     = ({1'b0, bcode_0_flag} + {1'b0, bcode_1_flag}) >> 1;
  localparam logic [24:0] T_1P     = ({1'b0, bcode_1_flag} + {1'b0, bcode_p_flag}) >> 1;
  localparam logic [24:0] T_MAX    = {1'b0, bcode_p_flag}
                                   + (({1'b0, bcode_p_flag} - {1'b0, bcode_1_flag}) >> 1);

  logic        s1, s2, s3;
  logic [23:0] cnt;
  logic [24:0] w;
  logic        rise, fall;
  sym_t        cls;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign w    = {1'b0, cnt};

  always_comb begin
    cls = SYM_ERR;
    if (w < T_01)       cls = SYM_0;
    else if (w < T_1P)  cls = SYM_1;
    else if (w <= T_MAX) cls = SYM_P;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      sym_valid <= 1'b0;
      sym       <= SYM_0;
    end else begin
      s1 <= ex_bcode_signal;
      s2 <= s1;
      s3 <= s2;
      if (rise)
        cnt <= '0;
      else if (s2 && cnt != 24'hFF_FFFF)
        cnt <= cnt + 24'd1;
      sym_valid <= fall && (w >= T_GLITCH);
      if (fall)
        sym <= cls;
    end
  end

endmodule

// File: rtl/irig_parse.sv
// IRIG-B frame aligner and BCD time extractor; outputs load together with a
// one-clk time_flag the clk after the index-59 marker is classified.
module irig_parse
  import irig_parse_pkg::*;
#(
  parameter logic [23:0] bcode_0_flag = 24'd99_999,
  parameter logic [23:0] bcode_1_flag = 24'd249_999,
  parameter logic [23:0] bcode_p_flag = 24'd399_999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_bcode_signal,
  output logic [3:0] second_units,
  output logic [2:0] second_tens,
  output logic [3:0] minute_units,
  output logic [2:0] minute_tens,
  output logic [3:0] hour_units,
  output logic [1:0] hour_tens,
  output logic [3:0] day_units,
  output logic [3:0] day_tens,
  output logic [1:0] day_hunds,
  output logic [3:0] year_units,
  output logic [3:0] year_tens,
  output logic       time_flag
);

  logic       sym_valid;
  sym_t       sym;
  state_t     state;
  logic [6:0] idx, nidx;
  logic       prev_p, b;
  irig_time_t shadow, cur;

  irig_symbol_classifier #(
    .bcode_0_flag(bcode_0_flag),
    .bcode_1_flag(bcode_1_flag),
    .bcode_p_flag(bcode_p_flag)
  ) u_cls (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_bcode_signal (ex_bcode_signal),
    .sym_valid       (sym_valid),
    .sym             (sym)
  );

  assign nidx = idx + 7'd1;
  assign b    = (sym == SYM_1);

  // Fields arrive LSB first: shifting in from the top leaves the first bit at bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      idx       <= '0;
      prev_p    <= 1'b0;
      shadow    <= '0;
      cur       <= '0;
      time_flag <= 1'b0;
    end else begin
      time_flag <= 1'b0;
      if (sym_valid) begin
        prev_p <= (sym == SYM_P);
        if (sym == SYM_P && prev_p) begin
          state  <= LOCKED;
          idx    <= '0;
          shadow <= '0;
        end else if (state == LOCKED) begin
          if (sym == SYM_ERR || idx >= 7'(LAST_IDX) || (is_marker(nidx) != (sym == SYM_P))) begin
            state <= HUNT;
            idx   <= '0;
          end else begin
            idx <= nidx;
            if (in_field(nidx, SEC_U_LSB, 4))  shadow.sec_u  <= {b, shadow.sec_u[3:1]};
            if (in_field(nidx, SEC_T_LSB, 3))  shadow.sec_t  <= {b, shadow.sec_t[2:1]};
            if (in_field(nidx, MIN_U_LSB, 4))  shadow.min_u  <= {b, shadow.min_u[3:1]};
            if (in_field(nidx, MIN_T_LSB, 3))  shadow.min_t  <= {b, shadow.min_t[2:1]};
            if (in_field(nidx, HOUR_U_LSB, 4)) shadow.hour_u <= {b, shadow.hour_u[3:1]};
            if (in_field(nidx, HOUR_T_LSB, 2)) shadow.hour_t <= {b, shadow.hour_t[1]};
            if (in_field(nidx, DAY_U_LSB, 4))  shadow.day_u  <= {b, shadow.day_u[3:1]};
            if (in_field(nidx, DAY_T_LSB, 4))  shadow.day_t  <= {b, shadow.day_t[3:1]};
            if (in_field(nidx, DAY_H_LSB, 2))  shadow.day_h  <= {b, shadow.day_h[1]};
            if (in_field(nidx, YEAR_U_LSB, 4)) shadow.year_u <= {b, shadow.year_u[3:1]};
            if (in_field(nidx, YEAR_T_LSB, 4)) shadow.year_t <= {b, shadow.year_t[3:1]};
            if (nidx == 7'(P6_IDX)) begin
              cur       <= shadow;
              time_flag <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign second_units = cur.sec_u;
  assign second_tens  = cur.sec_t;
  assign minute_units = cur.min_u;
  assign minute_tens  = cur.min_t;
  assign hour_units   = cur.hour_u;
  assign hour_tens    = cur.hour_t;
  assign day_units    = cur.day_u;
  assign day_tens     = cur.day_t;
  assign day_hunds    = cur.day_h;
  assign year_units   = cur.year_u;
  assign year_tens    = cur.year_t;

endmodule

// File: tb/tb_irig_parse.sv
// Directed bench for irig_parse with symbol widths scaled down (50-clk bit period).
module tb_irig_parse;

  localparam int S0 = 0, S1 = 1, SP = 2, SE = 3;
  localparam int PERIOD = 50;

  logic clk = 0, rst_n = 0, ex = 0;
  logic [3:0] second_units, minute_units, hour_units, day_units, day_tens, year_units, year_tens;
  logic [2:0] second_tens, minute_tens;
  logic [1:0] hour_tens, day_hunds;
  logic       time_flag;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, fall_cyc = 0, flag_cyc = 0, flag_gap = 0, flag_cnt = 0;
  int frame[100];

  irig_parse #(
    .bcode_0_flag(24'd9), .bcode_1_flag(24'd24), .bcode_p_flag(24'd39)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ex_bcode_signal(ex),
    .second_units(second_units), .second_tens(second_tens),
    .minute_units(minute_units), .minute_tens(minute_tens),
    .hour_units(hour_units), .hour_tens(hour_tens),
    .day_units(day_units), .day_tens(day_tens), .day_hunds(day_hunds),
    .year_units(year_units), .year_tens(year_tens),
    .time_flag(time_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (time_flag) begin
    flag_cnt++;
    flag_gap = cyc - flag_cyc;
    flag_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int su, st, mu, mt, hu, ht, du, dt, dh, yu, yt);
    chk({tag, ".sec_u"}, 32'(second_units), su);
    chk({tag, ".sec_t"}, 32'(second_tens), st);
    chk({tag, ".min_u"}, 32'(minute_units), mu);
    chk({tag, ".min_t"}, 32'(minute_tens), mt);
    chk({tag, ".hour_u"}, 32'(hour_units), hu);
    chk({tag, ".hour_t"}, 32'(hour_tens), ht);
    chk({tag, ".day_u"}, 32'(day_units), du);
    chk({tag, ".day_t"}, 32'(day_tens), dt);
    chk({tag, ".day_h"}, 32'(day_hunds), dh);
    chk({tag, ".year_u"}, 32'(year_units), yu);
    chk({tag, ".year_t"}, 32'(year_tens), yt);
  endtask

  task automatic put(input int lsb, input int w, input int val);
    for (int k = 0; k < w; k++) frame[lsb + k] = ((val >> k) & 1) ? S1 : S0;
  endtask

  task automatic build_frame(input int s, input int m, input int h, input int d, input int y);
    for (int i = 0; i < 100; i++) frame[i] = (i % 10 == 9 || i == 0) ? SP : S0;
    put(1, 4, s % 10);  put(6, 3, s / 10);
    put(10, 4, m % 10); put(15, 3, m / 10);
    put(20, 4, h % 10); put(25, 2, h / 10);
    put(30, 4, d % 10); put(35, 4, (d / 10) % 10); put(40, 2, d / 100);
    put(50, 4, y % 10); put(55, 4, y / 10);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // High width h gives a counted width of h-1 in the DUT
  task automatic send_sym(input int s, input bit glitch);
    int h;
    case (s)
      S0: h = 10;
      S1: h = 25;
      SP: h = 40;
      default: h = 48;
    endcase
    ex = 1'b1;
    wait_clk(h);
    ex = 1'b0;
    fall_cyc = cyc;
    if (glitch) begin
      wait_clk(3); ex = 1'b1;
      wait_clk(2); ex = 1'b0;
      wait_clk(PERIOD - h - 5);
    end else begin
      wait_clk(PERIOD - h);
    end
  endtask

  task automatic send_range(input int from, input int to, input bit glitch);
    for (int i = from; i <= to; i++) send_sym(frame[i], glitch);
  endtask

  initial begin
    wait_clk(3);
    chk("reset.flag", 32'(time_flag), 0);
    check_time("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    wait_clk(2);

    // Lead-in P, then frame 08 s, 48 min, 01 h, day 251, year 21
    send_sym(SP, 1'b0);
    build_frame(8, 48, 1, 251, 21);
    send_range(0, 58, 1'b0);
    chk("f1.no_early_flag", flag_cnt, 0);
    send_sym(frame[59], 1'b0);
    chk("f1.flag", flag_cnt, 1);
    chk("f1.flag_latency", flag_cyc - fall_cyc, 4);
    check_time("f1", 8, 0, 8, 4, 1, 0, 1, 5, 2, 1, 2);
    send_range(60, 99, 1'b0);

    // Continuous repeats: one flag per 100 symbols
    send_range(0, 99, 1'b0);
    send_range(0, 99, 1'b0);
    chk("rep.flags", flag_cnt, 3);
    chk("rep.gap", flag_gap, 100 * PERIOD);
    check_time("rep", 8, 0, 8, 4, 1, 0, 1, 5, 2, 1, 2);

    // Missing P at index 29 drops sync before the data would load
    build_frame(9, 12, 3, 45, 7);
    frame[29] = S0;
    send_range(0, 99, 1'b0);
    chk("badp.flags", flag_cnt, 3);
    check_time("badp", 8, 0, 8, 4, 1, 0, 1, 5, 2, 1, 2);

    // Over-long pulse at index 15 drops sync
    build_frame(9, 12, 3, 45, 7);
    frame[15] = SE;
    send_range(0, 99, 1'b0);
    chk("err.flags", flag_cnt, 3);
    check_time("err", 8, 0, 8, 4, 1, 0, 1, 5, 2, 1, 2);

    // Relock on the next Pr pair with new values
    build_frame(59, 37, 23, 366, 99);
    send_range(0, 99, 1'b0);
    chk("relock.flags", flag_cnt, 4);
    check_time("relock", 9, 5, 7, 3, 3, 2, 6, 6, 3, 9, 9);

    // Short glitches in every low period are ignored
    send_range(0, 99, 1'b1);
    chk("glitch.flags", flag_cnt, 5);
    check_time("glitch", 9, 5, 7, 3, 3, 2, 6, 6, 3, 9, 9);

    // Reset at index 40, then the rest of the frame must not load anything
    build_frame(8, 48, 1, 251, 21);
    send_range(0, 40, 1'b0);
    rst_n = 1'b0;
    #1;
    check_time("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst.flag", 32'(time_flag), 0);
    wait_clk(3);
    rst_n = 1'b1;
    send_range(41, 99, 1'b0);
    chk("rst.tail_flags", flag_cnt, 5);
    check_time("rst.tail", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    send_range(0, 99, 1'b0);
    chk("rst.relock_flags", flag_cnt, 6);
    check_time("rst.relock", 8, 0, 8, 4, 1, 0, 1, 5, 2, 1, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
